// File: rtl/suspend_ctrl_if.sv
// Bundle of the suspend controller's request, fetch-path and status signals.
// slave = the controller itself, master = the processor/test side driving requests.
interface suspend_ctrl_if #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 5,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic [NCH-1:0]       i_start_hold;
    logic [NCH*CNT_W-1:0] i_hold_len;
    logic [NCH-1:0]       i_hold_mode;
    logic [NCH-1:0]       i_release;
    logic [INSTR_W-1:0]   i_next_instr;
    logic [ADDR_W-1:0]    i_pc_next;

    logic                 o_hold;
    logic                 o_hold_out;
    logic                 o_end_hold;
    logic [CNT_W-1:0]     o_hold_count;
    logic [NCH-1:0]       o_hold_ch;
    logic [INSTR_W-1:0]   o_mod_next_instr;
    logic [ADDR_W-1:0]    o_pm_addr;
    logic                 o_req_dropped;

    modport slave (
        input  i_start_hold, i_hold_len, i_hold_mode, i_release, i_next_instr, i_pc_next,
        output o_hold, o_hold_out, o_end_hold, o_hold_count, o_hold_ch,
               o_mod_next_instr, o_pm_addr, o_req_dropped
    );

    modport master (
        output i_start_hold, i_hold_len, i_hold_mode, i_release, i_next_instr, i_pc_next,
        input  o_hold, o_hold_out, o_end_hold, o_hold_count, o_hold_ch,
               o_mod_next_instr, o_pm_addr, o_req_dropped
    );
endinterface

// File: rtl/suspend_ctrl.sv
// Multi-channel processor suspend controller: IDLE -> HOLD -> END, NOP injection and fetch replay.
// Define SUSPEND_PENDING_EN to queue ungranted requests in a pending mask instead of dropping them.
module suspend_ctrl #(
    parameter int                 NCH       = 4,
    parameter int                 CNT_W     = 5,
    parameter int                 ADDR_W    = 8,
    parameter int                 INSTR_W   = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic          clk,
    input  logic          reset,
    suspend_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         r_state, w_state_next;
    logic [CNT_W-1:0]   r_hold_count, w_hold_count_next;
    logic [NCH-1:0]     r_hold_ch, w_hold_ch_next;
    logic               r_mode, w_mode_next;
    logic [ADDR_W-1:0]  r_saved_addr, w_saved_addr_next;
    logic               r_hold_out;
    logic               r_req_dropped, w_req_dropped_next;

    logic [NCH-1:0]     w_req;
    logic [NCH-1:0]     w_prefix;
    logic [NCH-1:0]     w_grant_vec;
    logic [NCH-1:0]     w_ungranted;
    logic [NCH-1:0]     w_mode_masked;
    logic [CNT_W-1:0]   w_len_masked [NCH];
    logic [CNT_W-1:0]   w_sel_len;
    logic [CNT_W-1:0]   w_load_count;
    logic               w_sel_mode;
    logic               w_can_grant;
    logic               w_grant;
    logic               w_rel_hit;

`ifdef SUSPEND_PENDING_EN
    logic [NCH-1:0]     r_pending, w_pending_next;

    assign w_req = bus.i_start_hold | r_pending;
`else
    assign w_req = bus.i_start_hold;
`endif

    // A new hold may only be granted from IDLE or END, so back-to-back holds skip IDLE.
    assign w_can_grant = (r_state != S_HOLD);

    // Fixed lowest-index priority: a channel wins when no lower channel is requesting.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
            if (gi == 0) begin : gen_first
                assign w_prefix[gi] = 1'b0;
            end else begin : gen_rest
                assign w_prefix[gi] = w_prefix[gi-1] | w_req[gi-1];
            end
            assign w_grant_vec[gi]   = w_can_grant & w_req[gi] & ~w_prefix[gi];
            assign w_mode_masked[gi] = w_grant_vec[gi] & bus.i_hold_mode[gi];
            assign w_len_masked[gi]  = w_grant_vec[gi] ? bus.i_hold_len[gi*CNT_W +: CNT_W] : '0;
        end
    endgenerate

    always_comb begin
        w_sel_len = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sel_len = w_sel_len | w_len_masked[i];
        end
    end

    assign w_grant      = |w_grant_vec;
    assign w_sel_mode   = |w_mode_masked;
    assign w_load_count = w_sel_mode ? '0 : ((w_sel_len == '0) ? CNT_ONE : w_sel_len);
    assign w_rel_hit    = |(bus.i_release & r_hold_ch);
    assign w_ungranted  = bus.i_start_hold & ~w_grant_vec;

`ifdef SUSPEND_PENDING_EN
    // Only a request whose channel is already queued is lost; everything else waits its turn.
    assign w_pending_next     = (r_pending | bus.i_start_hold) & ~w_grant_vec;
    assign w_req_dropped_next = |(w_ungranted & r_pending);
`else
    assign w_req_dropped_next = |w_ungranted;
`endif

    // The counter is left untouched on the exit cycle, so END shows the value that ended the hold.
    always_comb begin
        w_state_next      = r_state;
        w_hold_count_next = r_hold_count;
        w_hold_ch_next    = r_hold_ch;
        w_mode_next       = r_mode;
        w_saved_addr_next = r_saved_addr;
        case (r_state)
            S_IDLE, S_END: begin
                if (w_grant) begin
                    w_state_next      = S_HOLD;
                    w_hold_ch_next    = w_grant_vec;
                    w_mode_next       = w_sel_mode;
                    w_saved_addr_next = bus.i_pc_next;
                    w_hold_count_next = w_load_count;
                end else begin
                    w_state_next      = S_IDLE;
                    w_hold_ch_next    = '0;
                    w_hold_count_next = '0;
                end
            end
            S_HOLD: begin
                if (!r_mode) begin
                    if (r_hold_count <= CNT_ONE) begin
                        w_state_next = S_END;
                    end else begin
                        w_hold_count_next = r_hold_count - CNT_ONE;
                    end
                end else if (w_rel_hit) begin
                    w_state_next = S_END;
                end else if (r_hold_count != CNT_MAX) begin
                    w_hold_count_next = r_hold_count + CNT_ONE;
                end
            end
            default: begin
                w_state_next      = S_IDLE;
                w_hold_ch_next    = '0;
                w_hold_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_hold_count  <= '0;
            r_hold_ch     <= '0;
            r_mode        <= 1'b0;
            r_saved_addr  <= '0;
            r_hold_out    <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hold_count  <= w_hold_count_next;
            r_hold_ch     <= w_hold_ch_next;
            r_mode        <= w_mode_next;
            r_saved_addr  <= w_saved_addr_next;
            r_hold_out    <= (r_state == S_HOLD);
            r_req_dropped <= w_req_dropped_next;
        end
    end

`ifdef SUSPEND_PENDING_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end
`endif

    // END replays the saved fetch address while the real instruction is let through.
    assign bus.o_hold           = (r_state == S_HOLD);
    assign bus.o_end_hold       = (r_state == S_END);
    assign bus.o_hold_out       = r_hold_out;
    assign bus.o_hold_count     = r_hold_count;
    assign bus.o_hold_ch        = r_hold_ch;
    assign bus.o_req_dropped    = r_req_dropped;
    assign bus.o_pm_addr        = (r_state == S_IDLE) ? bus.i_pc_next : r_saved_addr;
    assign bus.o_mod_next_instr = (r_state == S_HOLD) ? NOP_INSTR : bus.i_next_instr;

endmodule

// File: tb/tb_suspend_ctrl.sv
// Self-checking bench for suspend_ctrl: cycle model compared every negedge plus directed literal checks.
module tb_suspend_ctrl;
    localparam int NCH     = 4;
    localparam int CNT_W   = 5;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam logic [7:0] NOP = 8'hF0;
    localparam int CMAX = 31;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    suspend_ctrl_if #(.NCH(NCH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    suspend_ctrl #(
        .NCH(NCH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    bit         m_hold, m_end, m_mode, m_drop, m_hold_out;
    int         m_ch, m_cnt;
    logic [7:0] m_saved;
    logic [3:0] m_pend;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] st, req, gbit;
        logic [4:0] len;
        int g;
        if (!reset) begin
            m_hold = 0; m_end = 0; m_mode = 0; m_drop = 0; m_hold_out = 0;
            m_ch = 0; m_cnt = 0; m_saved = '0; m_pend = '0;
            return;
        end
        st = bus.i_start_hold;
`ifdef SUSPEND_PENDING_EN
        req = st | m_pend;
`else
        req = st;
`endif
        g = m_hold ? -1 : lowest(req);
        gbit = (g >= 0) ? 4'(1 << g) : 4'b0;
`ifdef SUSPEND_PENDING_EN
        m_drop = |(st & m_pend & ~gbit);
        m_pend = (m_pend | st) & ~gbit;
`else
        m_drop = |(st & ~gbit);
`endif
        m_hold_out = m_hold;
        if (m_hold) begin
            if (!m_mode) begin
                if (m_cnt == 1) begin m_hold = 0; m_end = 1; end
                else m_cnt--;
            end else begin
                if (bus.i_release[m_ch]) begin m_hold = 0; m_end = 1; end
                else if (m_cnt < CMAX) m_cnt++;
            end
        end else if (g >= 0) begin
            m_hold  = 1;
            m_end   = 0;
            m_ch    = g;
            m_mode  = bus.i_hold_mode[g];
            m_saved = bus.i_pc_next;
            len     = bus.i_hold_len[g*CNT_W +: CNT_W];
            m_cnt   = m_mode ? 0 : ((len == 0) ? 1 : int'(len));
        end else begin
            m_end = 0;
            m_cnt = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- every-cycle compare ----------------
    initial forever begin
        bit e_hold, e_end, e_hold_out, e_drop;
        int e_cnt, e_ch;
        logic [7:0] e_pm, e_instr;
        @(negedge clk);
        if (!reset) begin
            e_hold = 0; e_end = 0; e_hold_out = 0; e_drop = 0; e_cnt = 0; e_ch = 0;
            e_pm = bus.i_pc_next; e_instr = bus.i_next_instr;
        end else begin
            e_hold = m_hold; e_end = m_end; e_hold_out = m_hold_out; e_drop = m_drop;
            e_cnt = m_cnt;
            e_ch = (m_hold || m_end) ? (1 << m_ch) : 0;
            e_pm = (m_hold || m_end) ? m_saved : bus.i_pc_next;
            e_instr = m_hold ? NOP : bus.i_next_instr;
        end
        check("m_hold",     32'(bus.o_hold),           32'(e_hold));
        check("m_end_hold", 32'(bus.o_end_hold),       32'(e_end));
        check("m_hold_out", 32'(bus.o_hold_out),       32'(e_hold_out));
        check("m_dropped",  32'(bus.o_req_dropped),    32'(e_drop));
        check("m_count",    32'(bus.o_hold_count),     e_cnt);
        check("m_hold_ch",  32'(bus.o_hold_ch),        e_ch);
        check("m_pm_addr",  32'(bus.o_pm_addr),        32'(e_pm));
        check("m_instr",    32'(bus.o_mod_next_instr), 32'(e_instr));
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        bus.i_start_hold = '0;
        bus.i_hold_len   = '0;
        bus.i_hold_mode  = '0;
        bus.i_release    = '0;
        bus.i_next_instr = 8'h5A;
        bus.i_pc_next    = 8'h10;
        reset = 1'b0;
        repeat (2) tick();
        check("rst_hold",  32'(bus.o_hold), 0);
        check("rst_ch",    32'(bus.o_hold_ch), 0);
        check("rst_pm",    32'(bus.o_pm_addr), 32'h10);
        check("rst_instr", 32'(bus.o_mod_next_instr), 32'h5A);
        reset = 1'b1;
        tick();

        // fixed count of 5 on ch0
        bus.i_hold_len[0*CNT_W +: CNT_W] = 5'd5;
        bus.i_pc_next    = 8'hA0;
        bus.i_start_hold = 4'b0001;
        tick();
        bus.i_start_hold = '0;
        bus.i_pc_next    = 8'h33;
        check("t1_ch",  32'(bus.o_hold_ch), 1);
        check("t1_pm",  32'(bus.o_pm_addr), 32'hA0);
        check("t1_nop", 32'(bus.o_mod_next_instr), 32'hF0);
        for (int k = 5; k >= 1; k--) begin
            check("t1_hold", 32'(bus.o_hold), 1);
            check("t1_cnt",  32'(bus.o_hold_count), k);
            tick();
        end
        check("t1_end",      32'(bus.o_end_hold), 1);
        check("t1_end_hold", 32'(bus.o_hold), 0);
        check("t1_end_pm",   32'(bus.o_pm_addr), 32'hA0);
        check("t1_end_ins",  32'(bus.o_mod_next_instr), 32'h5A);
        check("t1_hold_out", 32'(bus.o_hold_out), 1);
        tick();
        check("t1_idle_end", 32'(bus.o_end_hold), 0);
        check("t1_idle_pm",  32'(bus.o_pm_addr), 32'h33);

        // zero length: exactly one HOLD cycle
        bus.i_hold_len[0*CNT_W +: CNT_W] = 5'd0;
        bus.i_pc_next    = 8'h44;
        bus.i_start_hold = 4'b0001;
        tick();
        bus.i_start_hold = '0;
        check("t2_hold", 32'(bus.o_hold), 1);
        check("t2_cnt",  32'(bus.o_hold_count), 1);
        check("t2_nop",  32'(bus.o_mod_next_instr), 32'hF0);
        tick();
        check("t2_end",  32'(bus.o_end_hold), 1);
        check("t2_ins",  32'(bus.o_mod_next_instr), 32'h5A);
        tick();
        check("t2_idle", 32'(bus.o_hold) | 32'(bus.o_end_hold), 0);

        // mode 1 on ch2, released after 9 cycles, then saturation
        bus.i_hold_mode  = 4'b0100;
        bus.i_pc_next    = 8'h77;
        bus.i_start_hold = 4'b0100;
        tick();
        bus.i_start_hold = '0;
        check("t3_ch",   32'(bus.o_hold_ch), 32'h4);
        check("t3_cnt0", 32'(bus.o_hold_count), 0);
        repeat (9) tick();
        check("t3_cnt9", 32'(bus.o_hold_count), 9);
        bus.i_release = 4'b0100;
        tick();
        bus.i_release = '0;
        check("t3_end",     32'(bus.o_end_hold), 1);
        check("t3_end_cnt", 32'(bus.o_hold_count), 9);
        tick();
        bus.i_start_hold = 4'b0100;
        tick();
        bus.i_start_hold = '0;
        repeat (40) tick();
        check("t3_sat",      32'(bus.o_hold_count), 31);
        check("t3_sat_hold", 32'(bus.o_hold), 1);
        bus.i_release = 4'b0100;
        tick();
        bus.i_release = '0;
        check("t3_sat_end", 32'(bus.o_end_hold), 1);
        tick();
        bus.i_hold_mode = '0;

        // simultaneous starts on ch1 and ch2
        bus.i_hold_len[1*CNT_W +: CNT_W] = 5'd2;
        bus.i_hold_len[2*CNT_W +: CNT_W] = 5'd3;
        bus.i_pc_next    = 8'h5C;
        bus.i_start_hold = 4'b0110;
        tick();
        bus.i_start_hold = '0;
        check("t4_ch1", 32'(bus.o_hold_ch), 32'h2);
        check("t4_cnt", 32'(bus.o_hold_count), 2);
`ifdef SUSPEND_PENDING_EN
        check("t4_drop", 32'(bus.o_req_dropped), 0);
`else
        check("t4_drop", 32'(bus.o_req_dropped), 1);
`endif
        tick();
        check("t4_drop_pulse", 32'(bus.o_req_dropped), 0);
        tick();
        check("t4_end", 32'(bus.o_end_hold), 1);
        tick();
`ifdef SUSPEND_PENDING_EN
        check("t4_ch2",    32'(bus.o_hold_ch), 32'h4);
        check("t4_ch2cnt", 32'(bus.o_hold_count), 3);
`else
        check("t4_ch2",    32'(bus.o_hold_ch), 0);
        check("t4_idle",   32'(bus.o_hold), 0);
`endif
        repeat (6) tick();

        // restart on the active channel, mode-0 release ignored, repeated pending request
        bus.i_hold_len[1*CNT_W +: CNT_W] = 5'd4;
        bus.i_start_hold = 4'b0010;
        tick();
        bus.i_start_hold = '0;
        tick();
        bus.i_start_hold = 4'b0011;
        bus.i_release    = 4'b0010;
        tick();
        bus.i_start_hold = 4'b0001;
        bus.i_release    = '0;
        check("t5_hold_on_rel", 32'(bus.o_hold), 1);
        tick();
        bus.i_start_hold = '0;
        check("t5_drop", 32'(bus.o_req_dropped), 1);
        repeat (15) tick();

        // asynchronous reset two cycles into a 5-cycle hold
        bus.i_hold_len[0*CNT_W +: CNT_W] = 5'd5;
        bus.i_pc_next    = 8'h90;
        bus.i_start_hold = 4'b0001;
        tick();
        bus.i_start_hold = '0;
        bus.i_pc_next    = 8'h91;
        tick();
        #1 reset = 1'b0;
        #1;
        check("t6_hold", 32'(bus.o_hold), 0);
        check("t6_cnt",  32'(bus.o_hold_count), 0);
        check("t6_ch",   32'(bus.o_hold_ch), 0);
        check("t6_pm",   32'(bus.o_pm_addr), 32'h91);
        check("t6_ins",  32'(bus.o_mod_next_instr), 32'h5A);
        tick();
        check("t6_noend", 32'(bus.o_end_hold), 0);
        reset = 1'b1;
        tick();
        check("t6_after", 32'(bus.o_hold) | 32'(bus.o_end_hold), 0);
        bus.i_hold_len[3*CNT_W +: CNT_W] = 5'd2;
        bus.i_start_hold = 4'b1000;
        tick();
        bus.i_start_hold = '0;
        check("t6_resume", 32'(bus.o_hold_ch), 32'h8);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
